// File: rtl/decode_stage.sv
// decode_stage: RV32 instruction decoder feeding a small ready/valid buffer of decoded entries.
// Optional macro DECODE_STAGE_UTYPE_EN enables LUI/AUIPC decoding as U-type.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_func3,
  output logic [6:0]       out_func7,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_size,
  output logic [7:0]       out_itype,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam int AW = $clog2(BUF_DEPTH);
`ifdef DECODE_STAGE_UTYPE_EN
  localparam bit UEN = 1'b1;
`else
  localparam bit UEN = 1'b0;
`endif
  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            size;
    logic [7:0]      itype;
    logic            illegal;
  } entry_t;
  logic [31:0] i;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        t_r, t_i, t_ld, t_st, t_br, t_jal, t_jalr, t_u, bad, ok;
  logic [7:0]  it;
  logic [31:0] imm32;
  entry_t      dec, head;
  entry_t      mem [BUF_DEPTH];
  logic [AW:0]   cnt;
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;
  assign i      = in_instr;
  assign op     = i[6:0];
  assign f3     = i[14:12];
  assign f7     = i[31:25];
  assign t_r    = op == 7'b0110011;
  assign t_i    = op == 7'b0010011;
  assign t_ld   = op == 7'b0000011;
  assign t_st   = op == 7'b0100011;
  assign t_br   = op == 7'b1100011;
  assign t_jal  = op == 7'b1101111;
  assign t_jalr = op == 7'b1100111;
  assign t_u    = UEN && (op == 7'b0110111 || op == 7'b0010111);
  assign it     = {t_u, t_jalr, t_jal, t_br, t_st, t_ld, t_i, t_r};
  // every supported opcode ends in 2'b11, so a bad low pair never matches a type
  assign bad = !(|it) || (t_r && f7 != 7'b0000000 && f7 != 7'b0100000) ||
               ((t_ld || t_st) && f3 != 3'b000 && f3 != 3'b010) || (t_jalr && f3 != 3'b000);
  assign ok  = !bad;
  assign imm32 = t_st  ? {{20{i[31]}}, i[31:25], i[11:7]} :
                 t_br  ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
                 t_jal ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} :
                 t_u   ? {i[31:12], 12'b0} :
                 (t_i || t_ld || t_jalr) ? {{20{i[31]}}, i[31:20]} : 32'b0;
  assign dec.opcode  = op;
  assign dec.rd      = (ok && (t_r || t_i || t_ld || t_jal || t_jalr || t_u)) ? i[11:7] : 5'b0;
  assign dec.func3   = (ok && (t_r || t_i || t_ld || t_st || t_br || t_jalr)) ? f3 : 3'b0;
  assign dec.rs1     = (ok && (t_r || t_i || t_ld || t_st || t_br || t_jalr)) ? i[19:15] : 5'b0;
  assign dec.rs2     = (ok && (t_r || t_st || t_br)) ? i[24:20] : 5'b0;
  assign dec.func7   = (ok && t_r) ? f7 : 7'b0;
  assign dec.imm     = ok ? XLEN'($signed(imm32)) : '0;
  assign dec.size    = ok && !((t_ld || t_st) && f3 == 3'b000);
  assign dec.itype   = ok ? it : 8'b0;
  assign dec.illegal = bad;
  assign in_ready  = cnt != (AW+1)'(BUF_DEPTH);
  assign out_valid = cnt != '0;
  assign do_push   = in_valid && in_ready;
  assign do_pop    = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt         <= '0;
      wp          <= '0;
      rp          <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
      wp  <= '0;
      rp  <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (do_push && dec.illegal && illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wp] <= dec;
  // empty buffer (including reset) presents all-zero fields
  assign head        = out_valid ? mem[rp] : '0;
  assign out_opcode  = head.opcode;
  assign out_func3   = head.func3;
  assign out_func7   = head.func7;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_imm     = head.imm;
  assign out_size    = head.size;
  assign out_itype   = head.itype;
  assign out_illegal = head.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage with directed instruction vectors.
module tb_decode_stage;
  localparam int XLEN = 32, BD = 2, CW = 2;
  logic clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [6:0] out_opcode, out_func7;
  logic [2:0] out_func3;
  logic [4:0] out_rs1, out_rs2, out_rd;
  logic [XLEN-1:0] out_imm;
  logic out_size, out_illegal;
  logic [7:0] out_itype;
  logic [CW-1:0] illegal_cnt;

  decode_stage #(.XLEN(XLEN), .BUF_DEPTH(BD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_func3(out_func3), .out_func7(out_func7), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_imm(out_imm), .out_size(out_size), .out_itype(out_itype),
    .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  typedef struct packed {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
    logic [31:0] imm; logic [7:0] it; logic ill; logic sz;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0, mcnt = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t ex(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] imm, input logic [7:0] it, input logic ill,
                              input logic sz);
    ex = '{op, f3, f7, rs1, rs2, rd, imm, it, ill, sz};
  endfunction

  function automatic exp_t ilx(input logic [6:0] op);
    ilx = ex(op, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endfunction

  // monitor: a pop happens at the next rising edge whenever valid and ready are high here
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pop: got opcode %0h want nothing", out_opcode);
      end else begin
        e = q.pop_front();
        chk("opcode", out_opcode, e.op);
        chk("func3", out_func3, e.f3);
        chk("func7", out_func7, e.f7);
        chk("rs1", out_rs1, e.rs1);
        chk("rs2", out_rs2, e.rs2);
        chk("rd", out_rd, e.rd);
        chk("imm", out_imm, e.imm);
        chk("itype", out_itype, e.it);
        chk("illegal", out_illegal, e.ill);
        if (!e.ill) chk("size", out_size, e.sz);
      end
    end

  task automatic send(input logic [31:0] ins, input exp_t x);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin total++; bad++; $display("FAIL send_timeout: in_ready got 0 want 1"); end
    in_valid = 1; in_instr = ins;
    @(posedge clk); #1;
    in_valid = 0;
    q.push_back(x);
    if (x.ill && mcnt < 3) mcnt++;
    chk("illegal_cnt", illegal_cnt, mcnt);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; in_instr = 0; out_ready = 1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cnt", illegal_cnt, 0);
    chk("rst_opcode", out_opcode, 0);
    chk("rst_imm", out_imm, 0);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    send(32'h00A30293, ex(7'h13, 0, 0, 6, 0, 5, 32'hA, 8'h02, 0, 1));
    send(32'hFE000EE3, ex(7'h63, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 8'h10, 0, 1));
    send(32'h002081B3, ex(7'h33, 0, 7'h00, 1, 2, 3, 0, 8'h01, 0, 1));
    send(32'h402081B3, ex(7'h33, 0, 7'h20, 1, 2, 3, 0, 8'h01, 0, 1));
    send(32'hFF812383, ex(7'h03, 2, 0, 2, 0, 7, 32'hFFFFFFF8, 8'h04, 0, 1));
    send(32'h00550223, ex(7'h23, 0, 0, 10, 5, 0, 32'h4, 8'h08, 0, 0));
    send(32'h001000EF, ex(7'h6F, 0, 0, 0, 0, 1, 32'h800, 8'h20, 0, 1));
    send(32'h00008067, ex(7'h67, 0, 0, 1, 0, 0, 0, 8'h40, 0, 1));
    send(32'h00000083, ex(7'h03, 0, 0, 0, 0, 1, 0, 8'h04, 0, 0));
    drain();
    // back-pressure: fill, try an extra push, then release
    out_ready = 0;
    send(32'h00A30293, ex(7'h13, 0, 0, 6, 0, 5, 32'hA, 8'h02, 0, 1));
    send(32'hFE000EE3, ex(7'h63, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 8'h10, 0, 1));
    chk("full_in_ready", in_ready, 0);
    in_valid = 1; in_instr = 32'h00000083;
    repeat (2) @(posedge clk);
    #1;
    chk("full_hold_ready", in_ready, 0);
    chk("full_hold_opcode", out_opcode, 7'h13);
    in_valid = 0; out_ready = 1;
    drain();
    @(posedge clk); #1;
    chk("after_full_valid", out_valid, 0);
    // flush with a simultaneous illegal push
    out_ready = 0;
    send(32'h00A30293, ex(7'h13, 0, 0, 6, 0, 5, 32'hA, 8'h02, 0, 1));
    in_valid = 1; in_instr = 32'hFFFFFFFF; flush = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0; q.delete();
    chk("flush_valid", out_valid, 0);
    chk("flush_cnt", illegal_cnt, mcnt);
    chk("flush_ready", in_ready, 1);
    out_ready = 1;
    send(32'h00009067, ilx(7'h67));
    send(32'h00001003, ilx(7'h03));
    send(32'h022081B3, ilx(7'h33));
    send(32'hFFFFFFFF, ilx(7'h7F));
    send(32'h00A30290, ilx(7'h10));
`ifdef DECODE_STAGE_UTYPE_EN
    send(32'h123452B7, ex(7'h37, 0, 0, 0, 0, 5, 32'h12345000, 8'h80, 0, 1));
`else
    send(32'h123452B7, ilx(7'h37));
`endif
    drain();
    // asynchronous reset in the middle of a cycle with buffered entries
    out_ready = 0;
    send(32'h002081B3, ex(7'h33, 0, 7'h00, 1, 2, 3, 0, 8'h01, 0, 1));
    send(32'h402081B3, ex(7'h33, 0, 7'h20, 1, 2, 3, 0, 8'h01, 0, 1));
    #2 rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_cnt", illegal_cnt, 0);
    chk("arst_opcode", out_opcode, 0);
    chk("arst_func7", out_func7, 0);
    q.delete(); mcnt = 0;
    @(posedge clk); #1; rst_n = 1; out_ready = 1;
    send(32'h00A30293, ex(7'h13, 0, 0, 6, 0, 5, 32'hA, 8'h02, 0, 1));
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, width of the sign-extended immediate output; legal values 32 and 64.
REQ-002 Parameter BUF_DEPTH, default 2, number of decoded-entry buffer slots; power of two and at least 2.
REQ-003 Parameter CNT_W, default 16, width of the illegal-instruction counter.
REQ-004 One clock; reset is asynchronous and active-low: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-005 flush input 1, synchronous discard of all buffered entries.
REQ-006 in_valid input 1, in_instr input 32 (raw RV32 instruction), in_ready output 1.
REQ-007 out_valid output 1, out_ready input 1, out_opcode output 7, out_func3 output 3, out_func7 output 7.
REQ-008 out_rs1, out_rs2 and out_rd are each output 5, register addresses.
REQ-009 out_imm output XLEN (sign-extended immediate), out_size output 1 (1 = word, 0 = byte).
REQ-010 out_itype output 8, one-hot, bit0..7 = R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, U.
REQ-011 out_illegal output 1, illegal_cnt output CNT_W.

Function
REQ-012 A push occurs when in_valid and in_ready are both high; a pop occurs when out_valid and out_ready are both high.
REQ-013 in_ready is high when occupancy is below BUF_DEPTH, with no combinational path from out_ready.
REQ-014 out_valid is high when occupancy is nonzero; all out_* fields present the head entry and are stable while out_valid is high and out_ready is low.
REQ-015 Latency is 1 cycle: an instruction pushed at edge N is visible at the head after edge N when the buffer was empty.
REQ-016 Simultaneous push and pop leave occupancy unchanged; read and write pointers wrap modulo BUF_DEPTH.
REQ-017 Fields are decoded as opcode[6:0], rd[11:7], func3[14:12], rs1[19:15], rs2[24:20], func7[31:25], only where the format defines them; undefined fields are 0, never X.
REQ-018 Immediates by format:
- I, LOAD, JALR: instr[31:20].
- STORE: {instr[31:25], instr[11:7]}.
- BRANCH: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, a byte offset, unshifted.
- JAL: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- U: {instr[31:12], 12'b0}.
- All immediates are sign-extended from their MSB to XLEN; for R-type the immediate is 0.
REQ-019 out_size is 0 for LOAD/STORE with func3 = 000, and 1 otherwise.
REQ-020 out_illegal is 1, and out_itype and all fields except out_opcode are 0, when any of the following holds:
- instr[1:0] is not 11;
- the opcode is unsupported;
- an R-type func7 is not 0000000 or 0100000;
- a LOAD/STORE func3 is not 000 or 010;
- a JALR func3 is not 000.
REQ-021 Illegal entries are buffered and popped like legal ones.
REQ-022 illegal_cnt increments by 1 on each push of an illegal entry and saturates at all-ones; flush does not clear it.
REQ-023 When flush is high at a clock edge:
- occupancy and both pointers become 0;
- a push in that same cycle is discarded and does not count;
- flush takes priority over push and pop.
REQ-024 When in_ready is low (full), in_valid is ignored and nothing is overwritten.

Reset
REQ-025 While rst_n is low: occupancy, pointers and illegal_cnt are 0; out_valid is 0; in_ready is 1; all out_* fields are 0.
REQ-026 Assertion of rst_n mid-transfer discards all buffered entries immediately without waiting for a clock edge; operation resumes on the first clk edge after deassertion.

Configuration
REQ-027 Macro DECODE_STAGE_UTYPE_EN defined: opcodes 0110111 (LUI) and 0010111 (AUIPC) decode as U-type with rd and the U immediate, and out_itype bit7 is set.
REQ-028 Macro DECODE_STAGE_UTYPE_EN undefined: those opcodes are illegal per REQ-020, and out_itype bit7 is constantly 0.

Verification
REQ-029 Push 0x00A30293 (addi x5,x6,10) into an empty buffer with out_ready=1 -> next cycle out_valid=1, itype=0x02, rd=5, rs1=6, imm=10, illegal=0.
REQ-030 Push 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC (XLEN=32), itype=0x10, rs1=0, rs2=0, rd=0.
REQ-031 Hold out_ready=0 and push BUF_DEPTH instructions -> in_ready=0; a further in_valid is ignored; release out_ready -> entries pop in order with no loss.
REQ-032 Push 0xFFFFFFFF -> out_illegal=1 and illegal_cnt increments; with CNT_W=2 push 5 illegal words -> illegal_cnt holds at 3.
REQ-033 Fill to 1 entry, then assert flush together with in_valid -> next cycle out_valid=0 and illegal_cnt is unchanged; pulse rst_n low mid-stream -> outputs go to 0 asynchronously.
REQ-034 Push 0x123452B7 (lui x5) -> with DECODE_STAGE_UTYPE_EN: imm=0x12345000, itype=0x80; without it: illegal=1.
